fwvip_wb_target_mem: RTL and testbench

Synthesizable Wishbone (classic, single-access) target backed by a local word-addressed memory. It is the responder end of the Wishbone initiator/target pair: in the back-to-back bench it sits behind the target-side interface, so the initiator agent can drive real RTL instead of the target BFM. Programmable wait states, byte-lane writes, out-of-range error responses and saturating ack/err counters make it usable both as a scoreboard reference and as a stress target.

---
 rtl/fwvip_wb_target_pkg.sv | 18 +
 rtl/fwvip_wb_target_ram.sv | 34 +++
 rtl/fwvip_wb_target_mem.sv | 152 +++++++++++++++
 tb/tb_fwvip_wb_target_mem.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwvip_wb_target_pkg.sv
// Shared types and constants for the Wishbone memory target.
// The state encoding, the byte-offset width and the counter width live here.
package fwvip_wb_target_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int CNT_W = 16;

    // Number of byte-offset bits below the word index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/fwvip_wb_target_ram.sv
// Single-port RAM with per-byte write enables; read data is registered (1 cycle).
// No backpressure: every enabled cycle performs the access.
module fwvip_wb_target_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdat,
    output logic [DATA_WIDTH-1:0]   rdat
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdat_q;

    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < NB; i++) begin
                if (we && be[i]) begin
                    mem[addr][i*8 +: 8] <= wdat[i*8 +: 8];
                end
            end
            rdat_q <= mem[addr];
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/fwvip_wb_target_mem.sv
// Wishbone classic target over local RAM; ack/err WAIT_STATES+1 cycles after the request.
// Wait states stall the initiator; dropping cyc during WAIT abandons the access.
module fwvip_wb_target_mem
    import fwvip_wb_target_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH-1:0]   dat_w,
    output logic [DATA_WIDTH-1:0]   dat_r,
    input  logic                    cyc,
    input  logic                    stb,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] sel,
    output logic                    ack,
    output logic                    err,
    output logic [CNT_W-1:0]        ack_count,
    output logic [CNT_W-1:0]        err_count
);

    localparam int NB       = DATA_WIDTH / 8;
    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] LIMIT =
        {{ADDR_WIDTH{1'b0}}, 1'b1} << (ADDR_LSB + DEPTH_LOG2);

    state_e                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  we_q, we_d;
    logic [NB-1:0]         sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

    logic [ADDR_WIDTH-1:0] req_adr;
    logic                  req_we;
    logic [NB-1:0]         req_sel;
    logic [DATA_WIDTH-1:0] req_dat;
    logic                  in_range;
    logic                  enter_resp;
    logic                  ram_en;
    logic [DATA_WIDTH-1:0] ram_rdat;

    always_comb begin
        // Zero wait states enter RESP straight from IDLE, so the RAM sees the live bus.
        req_adr  = (state_q == IDLE) ? adr   : adr_q;
        req_we   = (state_q == IDLE) ? we    : we_q;
        req_sel  = (state_q == IDLE) ? sel   : sel_q;
        req_dat  = (state_q == IDLE) ? dat_w : dat_q;
        in_range = {1'b0, req_adr} < LIMIT;

        state_d    = state_q;
        wcnt_d     = wcnt_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        dat_d      = dat_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (cyc && stb) begin
                    adr_d = adr;
                    we_d  = we;
                    sel_d = sel;
                    dat_d = dat_w;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        wcnt_d  = 4'(WAIT_STATES);
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!cyc) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == 4'd1) begin
                    state_d    = RESP;
                    wcnt_d     = '0;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ack_d     = enter_resp && in_range;
        err_d     = enter_resp && !in_range;
        // A reset on the edge that would enter RESP must not commit the write.
        ram_en    = enter_resp && in_range && reset_n;
        ack_cnt_d = (ack_q && ack_cnt_q != '1) ? ack_cnt_q + 1'b1 : ack_cnt_q;
        err_cnt_d = (err_q && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ack_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            ack_cnt_q <= ack_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    fwvip_wb_target_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (req_we),
        .be    (req_sel),
        .addr  (req_adr[ADDR_LSB +: DEPTH_LOG2]),
        .wdat  (req_dat),
        .rdat  (ram_rdat)
    );

    assign ack       = ack_q;
    assign err       = err_q;
    assign dat_r     = ack_q ? ram_rdat : '0;
    assign ack_count = ack_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_fwvip_wb_target_mem.sv
// Bench for fwvip_wb_target_mem: three targets (0, 3 and 5 wait states) share the bus
// signals except cyc; a scoreboard queue holds the response expected for each request.
module tb_fwvip_wb_target_mem;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] dat_w = '0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [SW-1:0] sel = '0;
    logic          cyc [3] = '{1'b0, 1'b0, 1'b0};
    logic [DW-1:0] dat_r [3];
    logic          ack [3];
    logic          err [3];
    logic [15:0]   ack_count [3];
    logic [15:0]   err_count [3];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic          is_err;
        logic          chk_dat;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] model [3][1024];
    logic          prev_resp [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clock = ~clock;

    fwvip_wb_target_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset_n(reset_n), .adr(adr), .dat_w(dat_w), .dat_r(dat_r[0]),
        .cyc(cyc[0]), .stb(stb), .we(we), .sel(sel), .ack(ack[0]), .err(err[0]),
        .ack_count(ack_count[0]), .err_count(err_count[0]));

    fwvip_wb_target_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset_n(reset_n), .adr(adr), .dat_w(dat_w), .dat_r(dat_r[1]),
        .cyc(cyc[1]), .stb(stb), .we(we), .sel(sel), .ack(ack[1]), .err(err[1]),
        .ack_count(ack_count[1]), .err_count(err_count[1]));

    fwvip_wb_target_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(10), .WAIT_STATES(5)) u_ws5 (
        .clock(clock), .reset_n(reset_n), .adr(adr), .dat_w(dat_w), .dat_r(dat_r[2]),
        .cyc(cyc[2]), .stb(stb), .we(we), .sel(sel), .ack(ack[2]), .err(err[2]),
        .ack_count(ack_count[2]), .err_count(err_count[2]));

    // Pulse rules and idle read data hold on every cycle outside reset.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (reset_n) begin
                n_cmp++;
                if ((ack[k] && err[k]) || ((ack[k] || err[k]) && prev_resp[k])) begin
                    n_bad++;
                    $display("FAIL pulse_rule dut%0d: ack=%b err=%b prev=%b, required single non-overlapping pulses",
                             k, ack[k], err[k], prev_resp[k]);
                end
                if (!ack[k]) begin
                    n_cmp++;
                    if (dat_r[k] !== '0) begin
                        n_bad++;
                        $display("FAIL dat_r_idle dut%0d: got %h, required 0", k, dat_r[k]);
                    end
                end
            end
            prev_resp[k] <= ack[k] | err[k];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // One complete access on target k; expected response comes from the memory model.
    task automatic access(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s, input int exp_lat);
        exp_t       e;
        int         lat;
        logic [9:0] idx;
        idx       = a[11:2];
        e.is_err  = (a >= 32'h1000);
        e.chk_dat = !w;
        e.dat     = '0;
        if (!e.is_err) begin
            if (w) begin
                for (int i = 0; i < SW; i++)
                    if (s[i]) model[k][idx][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                e.dat = model[k][idx];
            end
        end
        sb.push_back(e);
        @(negedge clock);
        adr = a; dat_w = d; we = w; sel = s; stb = 1'b1; cyc[k] = 1'b1;
        lat = 0;
        while (!(ack[k] || err[k]) && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!(ack[k] || err[k])) begin
            n_bad++;
            $display("FAIL access_timeout dut%0d adr=%h: no ack/err within %0d cycles", k, a, lat);
        end else begin
            if (ack[k] !== !e.is_err || err[k] !== e.is_err) begin
                n_bad++;
                $display("FAIL response dut%0d adr=%h: ack=%b err=%b, required err=%b",
                         k, a, ack[k], err[k], e.is_err);
            end
            n_cmp++;
            if (lat != exp_lat) begin
                n_bad++;
                $display("FAIL latency dut%0d adr=%h: got %0d cycles, required %0d", k, a, lat, exp_lat);
            end
            if (e.chk_dat) begin
                n_cmp++;
                if (dat_r[k] !== e.dat) begin
                    n_bad++;
                    $display("FAIL read_data dut%0d adr=%h: got %h, required %h", k, a, dat_r[k], e.dat);
                end
            end
        end
        stb = 1'b0; we = 1'b0; cyc[k] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            n_cmp += 3;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_resp dut%0d: ack=%b err=%b, required 0/0", k, ack[k], err[k]);
            end
            if (dat_r[k] !== '0) begin
                n_bad++;
                $display("FAIL reset_dat_r dut%0d: got %h, required 0", k, dat_r[k]);
            end
            if (ack_count[k] !== 16'h0 || err_count[k] !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_counts dut%0d: ack_count=%h err_count=%h, required 0/0",
                         k, ack_count[k], err_count[k]);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, 1);
        @(negedge clock);
        n_cmp++;
        if (ack_count[0] !== 16'd2) begin
            n_bad++;
            $display("FAIL basic_ack_count: got %0d, required 2", ack_count[0]);
        end
    endtask

    task automatic test_byte_lanes();
        access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1);
        access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1);
        access(0, 1'b1, 32'h24, 32'h77777777, 4'b0000, 1);
        access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1);
        access(0, 1'b1, 32'h23, 32'h99000000, 4'b1000, 1);
        access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1);
    endtask

    task automatic test_out_of_range();
        access(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1);
        access(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1);
        access(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1);
        access(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 1);
        access(0, 1'b0, 32'h0, 32'h0, 4'hF, 1);
        access(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 1);
        @(negedge clock);
        n_cmp++;
        if (err_count[0] !== 16'd3) begin
            n_bad++;
            $display("FAIL oor_err_count: got %0d, required 3", err_count[0]);
        end
    endtask

    task automatic test_wait_states();
        access(1, 1'b1, 32'h4, 32'hA5A50004, 4'hF, 4);
        access(1, 1'b0, 32'h4, 32'h0, 4'hF, 4);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   hits = 0;
        int   first_at = 0;
        int   second_at = 0;
        e.is_err = 1'b0; e.chk_dat = 1'b1; e.dat = model[1][1];
        sb.push_back(e);
        sb.push_back(e);
        @(negedge clock);
        adr = 32'h4; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (ack[1]) begin
                hits++;
                if (hits == 1) first_at = c; else second_at = c;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (dat_r[1] !== e.dat) begin
                        n_bad++;
                        $display("FAIL b2b_data cycle %0d: got %h, required %h", c, dat_r[1], e.dat);
                    end
                end
            end
            if (c == 9) begin
                stb = 1'b0; cyc[1] = 1'b0;
            end
        end
        sb.delete();
        n_cmp += 3;
        if (first_at != 4) begin
            n_bad++;
            $display("FAIL b2b_first_ack: at T+%0d, required T+4", first_at);
        end
        if (second_at != 9) begin
            n_bad++;
            $display("FAIL b2b_second_ack: at T+%0d, required T+9", second_at);
        end
        if (hits != 2) begin
            n_bad++;
            $display("FAIL b2b_ack_total: got %0d, required 2", hits);
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        access(2, 1'b1, 32'h8, 32'h12345678, 4'hF, 6);
        @(negedge clock);
        adr = 32'h8; dat_w = 32'h55; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc[2] = 1'b1;
        repeat (2) @(negedge clock);
        stb = 1'b0; we = 1'b0; cyc[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (ack[2] || err[2]) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL abort_response: got a response after abort, required none");
        end
        access(2, 1'b0, 32'h8, 32'h0, 4'hF, 6);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clock);
        adr = 32'h8; dat_w = 32'h99; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc[2] = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b0; stb = 1'b0; we = 1'b0; cyc[2] = 1'b0;
        @(negedge clock);
        n_cmp += 3;
        if (ack[2] !== 1'b0 || err[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_resp: ack=%b err=%b, required 0/0", ack[2], err[2]);
        end
        if (ack_count[2] !== 16'h0 || err_count[2] !== 16'h0) begin
            n_bad++;
            $display("FAIL midreset_counts dut2: ack_count=%h err_count=%h, required 0/0",
                     ack_count[2], err_count[2]);
        end
        if (ack_count[0] !== 16'h0 || err_count[0] !== 16'h0) begin
            n_bad++;
            $display("FAIL midreset_counts dut0: ack_count=%h err_count=%h, required 0/0",
                     ack_count[0], err_count[0]);
        end
        reset_n = 1'b1;
        access(2, 1'b0, 32'h8, 32'h0, 4'hF, 6);
    endtask

    // Counters are preset close to the limit so only a handful of real pulses cross it.
    task automatic test_saturation();
        @(negedge clock);
        force u_ws0.ack_cnt_d = 16'hFFFC;
        force u_ws0.err_cnt_d = 16'hFFFE;
        @(negedge clock);
        release u_ws0.ack_cnt_d;
        release u_ws0.err_cnt_d;
        access(0, 1'b1, 32'h30, 32'h1, 4'hF, 1);
        access(0, 1'b1, 32'h30, 32'h2, 4'hF, 1);
        @(negedge clock);
        n_cmp++;
        if (ack_count[0] !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sat_ack_pre: got %h, required FFFE", ack_count[0]);
        end
        for (int i = 0; i < 3; i++) access(0, 1'b1, 32'h30, 32'h3, 4'hF, 1);
        for (int i = 0; i < 3; i++) access(0, 1'b1, 32'h2000, 32'h4, 4'hF, 1);
        @(negedge clock);
        n_cmp += 2;
        if (ack_count[0] !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_ack: got %h, required FFFF", ack_count[0]);
        end
        if (err_count[0] !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_err: got %h, required FFFF", err_count[0]);
        end
        access(0, 1'b0, 32'h30, 32'h0, 4'hF, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_out_of_range();
        test_wait_states();
        test_back_to_back();
        test_abort();
        test_reset_mid_wait();
        test_saturation();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
